// File: rtl/banked_data_memory.sv
// banked_data_memory
//   Little-endian byte-addressed memory built from four byte-lane banks.
//   Supports the MIPS access modes NONE/BYTE/HALFWORD/WORD/WORDLEFT/WORDRIGHT,
//   with register merge for lwl/lwr and misalignment detection.
//   Request port : req_valid/req_ready handshake, req_write, req_mode,
//                  req_unsigned, req_addr, req_wdata, req_rt.
//   Response port: resp_valid/resp_ready, resp_rdata, resp_err; single-entry
//                  registered output, 1-cycle latency, held under backpressure.
//   Fetch port   : fetch_en, fetch_addr -> fetch_data (registered, read-first).
//   clk/rst      : single clock, synchronous active-high reset.
module banked_data_memory #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_mode,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic        fetch_en,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_data
);

  localparam int unsigned ROW_W = ADDR_WIDTH - 2;
  localparam int unsigned ROWS  = 1 << ROW_W;

  typedef enum logic [2:0] {
    MODE_NONE   = 3'd0,
    MODE_BYTE   = 3'd1,
    MODE_HALF   = 3'd2,
    MODE_WORD   = 3'd3,
    MODE_WLEFT  = 3'd4,
    MODE_WRIGHT = 3'd5
  } mode_e;

  logic [7:0] r_bank [4][ROWS];

  logic             r_resp_valid;
  logic [31:0]      r_resp_rdata;
  logic             r_resp_err;
  logic [31:0]      r_fetch_data;

  mode_e            w_mode;
  logic [1:0]       w_k;
  logic [ROW_W-1:0] w_row;
  logic [ROW_W-1:0] w_frow;
  logic [4:0]       w_sh_k;
  logic [4:0]       w_sh_nk;
  logic [3:0][7:0]  w_word;
  logic [3:0][7:0]  w_fword;
  logic [31:0]      w_rsh;
  logic             w_accept;
  logic             w_err;
  logic [31:0]      w_load;
  logic [3:0]       w_lane_en;
  logic [3:0][7:0]  w_lane_data;
  logic [3:0]       w_we;
  logic [31:0]      w_rdata_next;
  logic             w_unused;

  assign w_k     = req_addr[1:0];
  assign w_row   = req_addr[ADDR_WIDTH-1:2];
  assign w_frow  = fetch_addr[ADDR_WIDTH-1:2];
  assign w_sh_k  = {w_k, 3'b000};
  // 3-k == ~k for a 2-bit k, so this is 8*(3-k)
  assign w_sh_nk = {~w_k, 3'b000};

  assign req_ready = !r_resp_valid || resp_ready;
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    case (req_mode)
      3'd1:    w_mode = MODE_BYTE;
      3'd2:    w_mode = MODE_HALF;
      3'd3:    w_mode = MODE_WORD;
      3'd4:    w_mode = MODE_WLEFT;
      3'd5:    w_mode = MODE_WRIGHT;
      default: w_mode = MODE_NONE;
    endcase
  end

  always_comb begin
    w_word  = '0;
    w_fword = '0;
    for (int unsigned l = 0; l < 4; l++) begin
      w_word[l]  = r_bank[l][w_row];
      w_fword[l] = r_bank[l][w_frow];
    end
  end

  assign w_rsh = w_word >> w_sh_k;

  // Store data is pre-shifted/replicated so that lane l always takes
  // w_lane_data[l]; the mode only decides which lanes are enabled.
  always_comb begin
    w_err       = 1'b0;
    w_load      = '0;
    w_lane_en   = '0;
    w_lane_data = '0;
    case (w_mode)
      MODE_BYTE: begin
        w_load      = {{24{!req_unsigned && w_rsh[7]}}, w_rsh[7:0]};
        w_lane_en   = 4'b0001 << w_k;
        w_lane_data = {4{req_wdata[7:0]}};
      end
      MODE_HALF: begin
        w_err       = w_k[0];
        w_load      = {{16{!req_unsigned && w_rsh[15]}}, w_rsh[15:0]};
        w_lane_en   = 4'b0011 << w_k;
        w_lane_data = {2{req_wdata[15:0]}};
      end
      MODE_WORD: begin
        w_err       = (w_k != 2'd0);
        w_load      = w_word;
        w_lane_en   = '1;
        w_lane_data = req_wdata;
      end
      MODE_WLEFT: begin
        w_load      = (w_word << w_sh_nk) | (req_rt & ~(32'hFFFF_FFFF << w_sh_nk));
        w_lane_en   = 4'b1111 >> (~w_k);
        w_lane_data = req_wdata >> w_sh_nk;
      end
      MODE_WRIGHT: begin
        w_load      = (w_word >> w_sh_k) | (req_rt & ~(32'hFFFF_FFFF >> w_sh_k));
        w_lane_en   = 4'b1111 << w_k;
        w_lane_data = req_wdata << w_sh_k;
      end
      default: ;
    endcase
  end

  assign w_we         = (w_accept && req_write && !w_err && !rst) ? w_lane_en : '0;
  assign w_rdata_next = (req_write || w_err) ? '0 : w_load;

  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < 4; l++) begin
      if (w_we[l]) r_bank[l][w_row] <= w_lane_data[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_fetch_data <= '0;
    end else begin
      if (w_accept) begin
        r_resp_valid <= 1'b1;
        r_resp_rdata <= w_rdata_next;
        r_resp_err   <= w_err;
      end else if (resp_ready) begin
        r_resp_valid <= 1'b0;
      end
      if (fetch_en) r_fetch_data <= w_fword;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign fetch_data = r_fetch_data;

  assign w_unused = ^{req_addr[31:ADDR_WIDTH], fetch_addr[31:ADDR_WIDTH],
                      fetch_addr[1:0], w_rsh[31:16]};

endmodule

// File: doc/banked_data_memory.md
# banked_data_memory

Parametrised successor to the single-array byte memory: a little-endian, byte-addressed memory built from four byte-lane banks, with a valid/ready load/store request port, a registered response port with backpressure, and an independent registered instruction-fetch port. It implements the MIPS access modes NONE/BYTE/HALFWORD/WORD/WORDLEFT/WORDRIGHT, including register merge for lwl/lwr and misalignment detection. It sits between the CPU memory stage and the fetch stage, replacing the combinational-read memory.

## Interface
- ADDR_WIDTH, 16, byte-address bits used; depth = 2^ADDR_WIDTH bytes, each bank 2^(ADDR_WIDTH-2) entries; must be ≥ 3.
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid && ready.
- req_write  in  1  1 = store, 0 = load.
- req_mode  in  3  MemoryModes::readWriteModes (NONE=0, BYTE=1, HALFWORD=2, WORD=3, WORDLEFT=4, WORDRIGHT=5); 6/7 treated as NONE.
- req_unsigned  in  1  zero-extend BYTE/HALFWORD loads.
- req_addr  in  32  byte address; bits above ADDR_WIDTH-1 ignored (wrap).
- req_wdata  in  32  store data (rt).
- req_rt  in  32  current destination register value, merged by WORDLEFT/WORDRIGHT loads.
- resp_valid  out  1  response held until resp_ready.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  load result; 0 for stores, NONE, errors.
- resp_err  out  1  misaligned access.
- fetch_en  in  1  launch instruction fetch.
- fetch_addr  in  32  instruction address; bits [1:0] ignored.
- fetch_data  out  32  registered instruction word.

## Operation
- Byte a maps to lane a[1:0], row a[ADDR_WIDTH-1:2]; word value = {lane3,lane2,lane1,lane0}. Let k = req_addr[1:0].
- Alignment: HALFWORD with k[0]=1 or WORD with k≠0 → resp_err=1, no write, rdata 0. BYTE, WORDLEFT, WORDRIGHT never fault.
- Loads: BYTE → lane k, sign- or zero-extended; HALFWORD → lanes k+1:k, extended; WORD → full row.
- WORDLEFT load: result[31:8(3-k)] = bytes k..0 (lane k in MSB); lower bytes from req_rt.
- WORDRIGHT load: result[8(4-k)-1:0] = bytes 3..k (lane k in LSB); upper bytes from req_rt.
- Stores: per-lane write enables. BYTE lane k ← wdata[7:0]; HALFWORD lanes k,k+1 ← wdata[7:0],[15:8]; WORD all lanes.
- WORDLEFT store: lane k ← wdata[31:24], lane k-1 ← [23:16], … down to lane 0 (k+1 lanes).
- WORDRIGHT store: lane k ← wdata[7:0], lane k+1 ← [15:8], … up to lane 3 (4-k lanes).
- NONE: accepted; response rdata 0, err 0; no write.
- Every accepted request, store or load, produces exactly one response, in order.
- Memory contents are not reset; initial contents are undefined (simulation may preload).

## Timing
- Reset values: resp_valid=0, resp_rdata=0, resp_err=0, fetch_data=0; req_ready=1 the cycle after reset.
- req_ready = !resp_valid || resp_ready (single-entry output register; full throughput when consumer is always ready).
- Accept at edge N: store lanes written at edge N; load bank read at edge N; resp_valid=1 after edge N (1-cycle latency).
- resp_rdata and resp_err stay stable while resp_valid && !resp_ready.
- Load accepted the cycle after a store to the same address returns the new data. Same-cycle store and fetch to the same row: fetch returns the old data (read-first).
- Fetch: fetch_en at edge N → fetch_data = row(fetch_addr) after edge N; fetch_data holds while fetch_en=0. Independent of the request port, never stalled.
- rst high at an edge takes priority: no write is performed, the pending response is dropped, and outputs return to reset values.

## Test plan
- Store WORD 0x11223344 @0x100, then load BYTE unsigned @0x103 → 0x00000011; load HALFWORD signed @0x102 → 0x00001122. Store BYTE 0x80 @0x104, then load BYTE signed → 0xFFFFFF80.
- Word 0x11223344 @0x100, req_rt=0xAABBCCDD: WORDLEFT @0x101 → 0x3344CCDD; WORDRIGHT @0x102 → 0xAABB1122; WORDLEFT @0x103 → 0x11223344.
- Zeroed word @0x200, wdata 0xAABBCCDD: WORDLEFT store @0x201 → word 0x0000AABB. Zeroed word @0x204: WORDRIGHT store @0x206 → word 0xCCDD0000.
- WORD load @0x102 and HALFWORD store @0x105 → resp_err=1, rdata 0, memory unchanged.
- resp_ready=0 with back-to-back loads → first response held stable, req_ready=0, second request not accepted until resp_ready=1; order preserved; no lost or duplicated responses.
- Fetch @0x100 concurrent with WORD store 0xDEADBEEF @0x100 → fetch_data=0x11223344; next fetch → 0xDEADBEEF. Assert rst with a store pending → no write, all outputs return to 0.
